// File: rtl/row_loader_pkg.sv
// Shared types and helpers for the systolic row loader and its memA/memB neighbours.
// Also defines the elaboration-time width check used by modules that unpack row words.
package row_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StFlush,
        StRun,
        StDone
    } ld_state_t;

    // Length of one skewed compute pass over a DIM x DIM array.
    function automatic int unsigned run_cycles(input int unsigned dim);
        return 3 * dim - 2;
    endfunction

endpackage

`ifndef ROW_LOADER_CHECK_W
`define ROW_LOADER_CHECK_W(DW, BW, DM) \
    if ((DW) != (BW) * (DM)) begin : g_width_check \
        $error("row_loader: DATA_W must equal BITS_AB*DIM"); \
    end
`endif

// File: rtl/ld_counter.sv
// Width-parameterised up-counter with synchronous clear, increment and terminal count.
// Incrementing at the terminal value wraps back to zero.
module ld_counter #(
    parameter int unsigned Width  = 3,
    parameter int unsigned MaxVal = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o,
    output logic             tc_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    assign tc_o  = (cnt_q == Width'(MaxVal));
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = tc_o ? '0 : cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/row_loader.sv
// Loads DIM rows into memA then DIM rows into memB from a packed word stream,
// then enables the array for one skewed compute pass and pulses done.
module row_loader
    import row_loader_pkg::*;
#(
    parameter int unsigned BITS_AB = 8,
    parameter int unsigned DIM     = 8,
    parameter int unsigned DATA_W  = 64,
    localparam int unsigned RowW   = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [DATA_W-1:0]               in_data_i,
    output logic                            a_wr_en_o,
    output logic [RowW-1:0]                 a_row_o,
    output logic [DIM-1:0][BITS_AB-1:0]     a_in_o,
    output logic                            b_wr_en_o,
    output logic [RowW-1:0]                 b_row_o,
    output logic [DIM-1:0][BITS_AB-1:0]     b_in_o,
    output logic                            en_o,
    output logic                            busy_o,
    output logic                            done_o
);

    localparam int unsigned RunCycles = run_cycles(DIM);
    localparam int unsigned RunW      = (RunCycles > 1) ? $clog2(RunCycles) : 1;

    `ROW_LOADER_CHECK_W(DATA_W, BITS_AB, DIM)

    ld_state_t state_q, state_d;

    logic            accept;
    logic [RowW-1:0] row_cnt;
    logic            row_tc;
    logic [RunW-1:0] run_cnt;
    logic            run_tc;

    logic                        a_wr_en_q, a_wr_en_d;
    logic [RowW-1:0]             a_row_q, a_row_d;
    logic [DIM-1:0][BITS_AB-1:0] a_in_q, a_in_d;
    logic                        b_wr_en_q, b_wr_en_d;
    logic [RowW-1:0]             b_row_q, b_row_d;
    logic [DIM-1:0][BITS_AB-1:0] b_in_q, b_in_d;

    assign in_ready_o = (state_q == StLoadA) || (state_q == StLoadB);
    assign accept     = in_valid_i && in_ready_o;
    assign en_o       = (state_q == StRun);
    assign busy_o     = (state_q != StIdle);
    assign done_o     = (state_q == StDone);

    // Row counter wraps to 0 after row DIM-1, so the B load starts at row 0 on its own.
    ld_counter #(
        .Width  (RowW),
        .MaxVal (DIM - 1)
    ) u_row_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i ((state_q == StIdle) && start_i),
        .inc_i (accept),
        .cnt_o (row_cnt),
        .tc_o  (row_tc)
    );

    ld_counter #(
        .Width  (RunW),
        .MaxVal (RunCycles - 1)
    ) u_run_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (state_q != StRun),
        .inc_i (state_q == StRun),
        .cnt_o (run_cnt),
        .tc_o  (run_tc)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StLoadA;
            StLoadA: if (accept && row_tc) state_d = StLoadB;
            StLoadB: if (accept && row_tc) state_d = StFlush;
            StFlush: state_d = StRun;
            StRun:   if (run_tc) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Row address and data hold their last value between writes; only the strobe drops.
    always_comb begin
        a_wr_en_d = accept && (state_q == StLoadA);
        b_wr_en_d = accept && (state_q == StLoadB);
        a_row_d   = a_row_q;
        a_in_d    = a_in_q;
        b_row_d   = b_row_q;
        b_in_d    = b_in_q;
        if (a_wr_en_d) begin
            a_row_d = row_cnt;
            a_in_d  = in_data_i;
        end
        if (b_wr_en_d) begin
            b_row_d = row_cnt;
            b_in_d  = in_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            a_wr_en_q <= 1'b0;
            a_row_q   <= '0;
            a_in_q    <= '0;
            b_wr_en_q <= 1'b0;
            b_row_q   <= '0;
            b_in_q    <= '0;
        end else begin
            state_q   <= state_d;
            a_wr_en_q <= a_wr_en_d;
            a_row_q   <= a_row_d;
            a_in_q    <= a_in_d;
            b_wr_en_q <= b_wr_en_d;
            b_row_q   <= b_row_d;
            b_in_q    <= b_in_d;
        end
    end

    assign a_wr_en_o = a_wr_en_q;
    assign a_row_o   = a_row_q;
    assign a_in_o    = a_in_q;
    assign b_wr_en_o = b_wr_en_q;
    assign b_row_o   = b_row_q;
    assign b_in_o    = b_in_q;

    // The run counter must be idle whenever the array is not running.
    assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q != StRun) |-> (run_cnt == '0));

endmodule

// File: tb/tb_row_loader.sv
// Scoreboard bench for row_loader: expected row writes are queued as words are driven
// and popped as the DUT strobes memA/memB; run-pass timing is checked per scenario.
module tb_row_loader;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [63:0] in_data_i = '0;
    logic        a_wr_en_o, b_wr_en_o, en_o, busy_o, done_o;
    logic [2:0]  a_row_o, b_row_o;
    logic [7:0][7:0] a_in_o, b_in_o;

    row_loader #(
        .BITS_AB (8),
        .DIM     (8),
        .DATA_W  (64)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .a_wr_en_o  (a_wr_en_o),
        .a_row_o    (a_row_o),
        .a_in_o     (a_in_o),
        .b_wr_en_o  (b_wr_en_o),
        .b_row_o    (b_row_o),
        .b_in_o     (b_in_o),
        .en_o       (en_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        is_b;
        logic [2:0]  row;
        logic [63:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  wr_cnt, en_cnt, done_cnt, first_en, last_en, done_cyc, lastb_cyc;

    function automatic logic [63:0] make_word(input int r, input int mode);
        logic [63:0] w;
        if (mode == 2 && r == 0) begin
            w = 64'h80FF_7F01_0000_00FF;
        end else begin
            for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(r + j + 1);
        end
        return w;
    endfunction

    // Write scoreboard and per-cycle enable/done bookkeeping.
    initial begin
        wr_t         e;
        logic        got_b;
        logic [2:0]  got_row;
        logic [63:0] got_data;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (a_wr_en_o || b_wr_en_o) begin
                wr_cnt++;
                n_tests++;
                got_b    = b_wr_en_o;
                got_row  = got_b ? b_row_o : a_row_o;
                got_data = got_b ? b_in_o : a_in_o;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: b=%0b row=%0d data=%h, required no write",
                             got_b, got_row, got_data);
                end else begin
                    e = exp_q.pop_front();
                    if ((a_wr_en_o && b_wr_en_o) || got_b !== e.is_b || got_row !== e.row
                        || got_data !== e.data) begin
                        n_fail++;
                        $display("FAIL write: a=%0b b=%0b row=%0d data=%h, required b=%0b row=%0d data=%h",
                                 a_wr_en_o, b_wr_en_o, got_row, got_data, e.is_b, e.row, e.data);
                    end
                    if (got_b && got_row == 3'd7) lastb_cyc = cyc;
                end
            end
            if (en_o) begin
                en_cnt++;
                if (en_cnt == 1) first_en = cyc;
                last_en = cyc;
                n_tests++;
                if (a_wr_en_o || b_wr_en_o) begin
                    n_fail++;
                    $display("FAIL en_overlap: en=1 a_wr=%0b b_wr=%0b, required no write",
                             a_wr_en_o, b_wr_en_o);
                end
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic send_words(input int n, input int mode, input bit glitch, output bit ok);
        int idx = 0;
        int c = 0;
        int waits = 0;
        bit glitched = 1'b0;
        ok = 1'b1;
        while (idx < n) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (glitch && idx == 10 && !glitched) begin
                start_i  = 1'b1;
                glitched = 1'b1;
            end
            if (mode == 1 && (c % 3) != 0) begin
                in_valid_i = 1'b0;
                c++;
                continue;
            end
            c++;
            if (!in_ready_o) begin
                in_valid_i = 1'b0;
                waits++;
                if (waits > 50) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ready_timeout: in_ready=%0b at word %0d, required 1", in_ready_o, idx);
                    ok = 1'b0;
                    return;
                end
                continue;
            end
            in_valid_i = 1'b1;
            in_data_i  = make_word(idx, mode);
            exp_q.push_back('{is_b: (idx >= 8), row: 3'(idx % 8), data: in_data_i});
            idx++;
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        start_i    = 1'b0;
    endtask

    task automatic run_pass(input int mode, input bit glitch, input string name);
        bit ok;
        int k;
        wr_cnt = 0; en_cnt = 0; done_cnt = 0;
        first_en = -1; last_en = -1; done_cyc = -1; lastb_cyc = -1;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        n_tests++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_busy_rise: busy=%b, required 1", name, busy_o);
        end
        send_words(16, mode, glitch, ok);
        if (!ok) return;
        if (glitch) begin
            k = 0;
            while (en_cnt < 5 && k < 100) begin
                @(negedge clk_i);
                k++;
            end
            start_i = 1'b1;
            @(negedge clk_i);
            start_i = 1'b0;
        end
        k = 0;
        while (done_cnt == 0 && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        n_tests++;
        if (done_cnt == 0) begin
            n_fail++;
            $display("FAIL %s_done_timeout: done_cnt=%0d, required 1", name, done_cnt);
            return;
        end
        repeat (4) @(negedge clk_i);
        n_tests++;
        if (wr_cnt !== 16 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL %s_writes: writes=%0d pending=%0d, required 16 and 0",
                     name, wr_cnt, exp_q.size());
        end
        n_tests++;
        if (en_cnt !== 22 || (last_en - first_en + 1) !== 22) begin
            n_fail++;
            $display("FAIL %s_en_len: en_cycles=%0d span=%0d, required 22", name, en_cnt,
                     last_en - first_en + 1);
        end
        n_tests++;
        if (first_en !== lastb_cyc + 1) begin
            n_fail++;
            $display("FAIL %s_en_start: first_en=%0d, required %0d", name, first_en, lastb_cyc + 1);
        end
        n_tests++;
        if (done_cnt !== 1 || done_cyc !== last_en + 1) begin
            n_fail++;
            $display("FAIL %s_done: pulses=%0d at %0d, required 1 at %0d", name, done_cnt,
                     done_cyc, last_en + 1);
        end
        n_tests++;
        if (busy_o !== 1'b0 || in_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: busy=%b in_ready=%b, required 0 0", name, busy_o, in_ready_o);
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1; in_valid_i = 1'b1; in_data_i = '1; start_i = 1'b0;
        repeat (2) @(negedge clk_i);
        n_tests++;
        if ({in_ready_o, a_wr_en_o, b_wr_en_o, en_o, busy_o, done_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: rdy/awr/bwr/en/busy/done=%b, required 000000",
                     {in_ready_o, a_wr_en_o, b_wr_en_o, en_o, busy_o, done_o});
        end
        n_tests++;
        if (a_row_o !== 3'd0 || b_row_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_rows: a_row=%0d b_row=%0d, required 0 0", a_row_o, b_row_o);
        end
        n_tests++;
        if (a_in_o !== 64'd0 || b_in_o !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_data: a_in=%h b_in=%h, required 0", a_in_o, b_in_o);
        end
        rst_i  = 1'b0;
        wr_cnt = 0;
        repeat (3) @(negedge clk_i);
        n_tests++;
        if (in_ready_o !== 1'b0 || busy_o !== 1'b0 || wr_cnt !== 0) begin
            n_fail++;
            $display("FAIL idle_no_consume: in_ready=%b busy=%b writes=%0d, required 0 0 0",
                     in_ready_o, busy_o, wr_cnt);
        end
        in_valid_i = 1'b0;
    endtask

    task automatic test_signed;
        bit ok;
        int exp_l[8] = '{-1, 0, 0, 0, 1, 127, -1, -128};
        int got;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        send_words(1, 2, 1'b0, ok);
        @(negedge clk_i);
        for (int j = 0; j < 8; j++) begin
            got = $signed(a_in_o[j]);
            n_tests++;
            if (got !== exp_l[j]) begin
                n_fail++;
                $display("FAIL signed_lane%0d: got %0d, required %0d", j, got, exp_l[j]);
            end
        end
        n_tests++;
        if (a_wr_en_o !== 1'b0 || a_row_o !== 3'd0) begin
            n_fail++;
            $display("FAIL signed_hold: a_wr=%b a_row=%0d, required 0 0", a_wr_en_o, a_row_o);
        end
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit ok;
        wr_cnt = 0;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        send_words(5, 0, 1'b0, ok);
        @(negedge clk_i);
        n_tests++;
        if (wr_cnt !== 5 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL mid_partial: writes=%0d pending=%0d, required 5 0", wr_cnt, exp_q.size());
        end
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        n_tests++;
        if (busy_o !== 1'b0 || in_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b in_ready=%b, required 0 0", busy_o, in_ready_o);
        end
        run_pass(0, 1'b0, "after_reset");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        run_pass(0, 1'b0, "back_to_back");
        run_pass(1, 1'b0, "gaps");
        test_signed();
        run_pass(0, 1'b1, "ignored_start");
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
